// File: rtl/tournament_bpu_if.sv
// Fetch/resolve bus between the core and the tournament branch predictor.
interface tournament_bpu_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      pcF;
    logic             stall;
    logic             flushD;
    logic             branchM;
    logic             pcsrcM;
    logic             pmis;
    logic             pcsrcPF;
    logic             flushE;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport master (
        output pcF, stall, flushD, branchM, pcsrcM, pmis,
        input  pcsrcPF, flushE, br_cnt, mis_cnt
    );

    modport slave (
        input  pcF, stall, flushD, branchM, pcsrcM, pmis,
        output pcsrcPF, flushE, br_cnt, mis_cnt
    );
endinterface

// File: rtl/tournament_bpu.sv
// Tournament direction predictor: local (per-PC BHR) and global (GHR) 2-bit PHTs with a chooser,
// trained at M with the indices captured at fetch and carried down the pipe.
module tournament_bpu #(
    parameter int PHT_DEPTH = 7,
    parameter int BHT_DEPTH = 3,
    parameter int GHR_WIDTH = 4,
    parameter int HASH_MODE = 0,
    parameter int CNT_W     = 32
) (
    input logic              clk,
    input logic              rst,
    tournament_bpu_if.slave  bus
);
    localparam int PHT_N = 1 << PHT_DEPTH;
    localparam int BHT_N = 1 << BHT_DEPTH;
    localparam int BHR_W = PHT_DEPTH - BHT_DEPTH;

    typedef struct packed {
        logic                 pl;
        logic                 pg;
        logic [PHT_DEPTH-1:0] lidx;
        logic [PHT_DEPTH-1:0] gidx;
        logic [BHT_DEPTH-1:0] bidx;
    } stage_t;

    logic [1:0]           lpht_q [PHT_N];
    logic [1:0]           gpht_q [PHT_N];
    logic [1:0]           cho_q  [PHT_N];
    logic [BHR_W-1:0]     bht_q  [BHT_N];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    stage_t               f_ent, fd_q, fd_d, de_q, de_d, em_q, em_d;
    logic [CNT_W-1:0]     br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    logic [BHT_DEPTH-1:0] bidx_f;
    logic [PHT_DEPTH-1:0] lidx_f, gidx_f;
    logic                 pl_f, pg_f;
    logic                 upd, t;
    logic [1:0]           lpht_nxt, gpht_nxt, cho_nxt;
    logic [BHR_W-1:0]     bht_nxt;
    logic                 unused_pc;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        else    return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Only a slice of the PC feeds the tables; fold the rest so it is visibly consumed.
    assign unused_pc = ^bus.pcF;

    assign bidx_f = bus.pcF[BHT_DEPTH+1:2];
    assign lidx_f = {bidx_f, bht_q[bidx_f]};

    generate
        if (HASH_MODE == 1) begin : g_gshare
            assign gidx_f = bus.pcF[PHT_DEPTH+1:2] ^ PHT_DEPTH'(ghr_q);
        end else if (GHR_WIDTH == PHT_DEPTH) begin : g_ghr_only
            assign gidx_f = ghr_q;
        end else begin : g_concat
            assign gidx_f = {bus.pcF[PHT_DEPTH-GHR_WIDTH+1:2], ghr_q};
        end
    endgenerate

    assign pl_f        = lpht_q[lidx_f][1];
    assign pg_f        = gpht_q[gidx_f][1];
    assign bus.pcsrcPF = cho_q[gidx_f][1] ? pl_f : pg_f;
    assign bus.flushE  = bus.pmis;
    assign bus.br_cnt  = br_cnt_q;
    assign bus.mis_cnt = mis_cnt_q;

    assign f_ent = '{pl: pl_f, pg: pg_f, lidx: lidx_f, gidx: gidx_f, bidx: bidx_f};

    // Flush beats stall on each stage register; E/M only ever holds or loads.
    assign fd_d = bus.flushD ? stage_t'('0) : (bus.stall ? fd_q : f_ent);
    assign de_d = bus.pmis   ? stage_t'('0) : (bus.stall ? de_q : fd_q);
    assign em_d = bus.stall  ? em_q : de_q;

    assign upd = bus.branchM & ~bus.stall;
    assign t   = bus.pcsrcM;

    assign lpht_nxt = sat2(lpht_q[em_q.lidx], t);
    assign gpht_nxt = sat2(gpht_q[em_q.gidx], t);
    assign bht_nxt  = BHR_W'({bht_q[em_q.bidx], t});
    assign ghr_d    = upd ? GHR_WIDTH'({ghr_q, t}) : ghr_q;

    always_comb begin
        cho_nxt = cho_q[em_q.gidx];
        if ((em_q.pg != t) && (em_q.pl == t))
            cho_nxt = sat2(cho_q[em_q.gidx], 1'b1);
        else if ((em_q.pl != t) && (em_q.pg == t))
            cho_nxt = sat2(cho_q[em_q.gidx], 1'b0);
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (upd && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (upd && bus.pmis && (mis_cnt_q != '1))
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                lpht_q[i] <= 2'b01;
                gpht_q[i] <= 2'b01;
                cho_q[i]  <= 2'b01;
            end
            for (int i = 0; i < BHT_N; i++)
                bht_q[i] <= '0;
            ghr_q     <= '0;
            fd_q      <= '0;
            de_q      <= '0;
            em_q      <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            fd_q      <= fd_d;
            de_q      <= de_d;
            em_q      <= em_d;
            ghr_q     <= ghr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (upd) begin
                lpht_q[em_q.lidx] <= lpht_nxt;
                gpht_q[em_q.gidx] <= gpht_nxt;
                cho_q[em_q.gidx]  <= cho_nxt;
                bht_q[em_q.bidx]  <= bht_nxt;
            end
        end
    end
endmodule

// File: tb/tb_tournament_bpu.sv
// Directed bench: default-parameter predictor plus a gshare/4-bit-counter variant.
module tb_tournament_bpu;
    localparam logic [31:0] PC_P = 32'h0040_0010;
    localparam logic [31:0] PC_Q = 32'h0040_0038;
    localparam logic [31:0] PC_X = 32'h0040_0020;
    // {pl,pg,lidx,gidx,bidx} of PC_P once its history is 1111 and both PHT entries are 11
    localparam logic [18:0] ENT_P = {1'b1, 1'b1, 7'h4F, 7'h4F, 3'd4};

    logic clk = 1'b0;
    logic rst, rst_a;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    tournament_bpu_if #(.CNT_W(32)) bi();
    tournament_bpu_if #(.CNT_W(4))  ba();

    tournament_bpu dut (.clk(clk), .rst(rst), .bus(bi));
    tournament_bpu #(.HASH_MODE(1), .CNT_W(4)) u_alt (.clk(clk), .rst(rst_a), .bus(ba));

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        bi.pcF = PC_P; bi.stall = 0; bi.flushD = 0; bi.branchM = 0; bi.pcsrcM = 0; bi.pmis = 0;
        ba.pcF = PC_P; ba.stall = 0; ba.flushD = 0; ba.branchM = 0; ba.pcsrcM = 0; ba.pmis = 0;
    endtask

    // Fetch pc, carry it F->D->E->M, train at M with direction tk; pred is the fetch-time prediction.
    task automatic br_main(input logic [31:0] pc, input logic tk, output logic pred);
        bi.pcF = pc; bi.branchM = 0;
        #1 pred = bi.pcsrcPF;
        tick; tick; tick;
        bi.branchM = 1; bi.pcsrcM = tk;
        tick;
        bi.branchM = 0; bi.pcsrcM = 0;
    endtask

    task automatic br_alt(input logic [31:0] pc, input logic tk, output logic pred);
        ba.pcF = pc; ba.branchM = 0;
        #1 pred = ba.pcsrcPF;
        tick; tick; tick;
        ba.branchM = 1; ba.pcsrcM = tk;
        tick;
        ba.branchM = 0; ba.pcsrcM = 0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1; rst_a = 1;
        tick; tick;
        rst = 0; rst_a = 0;
        #1;
        n_cmp++; if (bi.pcsrcPF !== 1'b0) begin n_mis++; $display("FAIL reset_pred got %b want 0", bi.pcsrcPF); end
        n_cmp++; if (bi.br_cnt !== 32'd0) begin n_mis++; $display("FAIL reset_br_cnt got %0d want 0", bi.br_cnt); end
        n_cmp++; if (bi.mis_cnt !== 32'd0) begin n_mis++; $display("FAIL reset_mis_cnt got %0d want 0", bi.mis_cnt); end
        n_cmp++; if (ba.br_cnt !== 4'd0) begin n_mis++; $display("FAIL reset_alt_br_cnt got %0d want 0", ba.br_cnt); end
        n_cmp++; if (bi.flushE !== 1'b0) begin n_mis++; $display("FAIL flushE_low got %b want 0", bi.flushE); end
        bi.pmis = 1;
        #1;
        n_cmp++; if (bi.flushE !== 1'b1) begin n_mis++; $display("FAIL flushE_high got %b want 1", bi.flushE); end
        bi.pmis = 0;
        #1;
    endtask

    task automatic test_taken_train;
        logic p;
        logic exp_p [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            br_main(PC_P, 1'b1, p);
            n_cmp++; if (p !== exp_p[i]) begin n_mis++; $display("FAIL taken_pred[%0d] got %b want %b", i, p, exp_p[i]); end
        end
        #1;
        n_cmp++; if (bi.pcsrcPF !== 1'b1) begin n_mis++; $display("FAIL taken_final_pred got %b want 1", bi.pcsrcPF); end
        n_cmp++; if (dut.ghr_q !== 4'hF) begin n_mis++; $display("FAIL taken_ghr got %h want f", dut.ghr_q); end
        n_cmp++; if (bi.br_cnt !== 32'd6) begin n_mis++; $display("FAIL taken_br_cnt got %0d want 6", bi.br_cnt); end
        n_cmp++; if (bi.mis_cnt !== 32'd0) begin n_mis++; $display("FAIL taken_mis_cnt got %0d want 0", bi.mis_cnt); end
    endtask

    task automatic test_stall;
        bi.pcF = PC_P;
        tick; tick; tick;
        n_cmp++; if (dut.em_q !== ENT_P) begin n_mis++; $display("FAIL stall_pre_em got %h want %h", dut.em_q, ENT_P); end
        bi.pcF = PC_X; bi.stall = 1; bi.branchM = 1; bi.pcsrcM = 0;
        tick; tick; tick;
        n_cmp++; if (dut.fd_q !== ENT_P) begin n_mis++; $display("FAIL stall_fd got %h want %h", dut.fd_q, ENT_P); end
        n_cmp++; if (dut.de_q !== ENT_P) begin n_mis++; $display("FAIL stall_de got %h want %h", dut.de_q, ENT_P); end
        n_cmp++; if (dut.em_q !== ENT_P) begin n_mis++; $display("FAIL stall_em got %h want %h", dut.em_q, ENT_P); end
        n_cmp++; if (dut.ghr_q !== 4'hF) begin n_mis++; $display("FAIL stall_ghr got %h want f", dut.ghr_q); end
        n_cmp++; if (dut.bht_q[4] !== 4'hF) begin n_mis++; $display("FAIL stall_bht got %h want f", dut.bht_q[4]); end
        n_cmp++; if (dut.lpht_q[7'h4F] !== 2'b11) begin n_mis++; $display("FAIL stall_lpht got %b want 11", dut.lpht_q[7'h4F]); end
        n_cmp++; if (dut.gpht_q[7'h4F] !== 2'b11) begin n_mis++; $display("FAIL stall_gpht got %b want 11", dut.gpht_q[7'h4F]); end
        n_cmp++; if (bi.br_cnt !== 32'd6) begin n_mis++; $display("FAIL stall_br_cnt got %0d want 6", bi.br_cnt); end
        bi.pmis = 1;
        #1;
        n_cmp++; if (bi.flushE !== 1'b1) begin n_mis++; $display("FAIL stall_flushE got %b want 1", bi.flushE); end
        tick;
        n_cmp++; if (dut.de_q !== 19'd0) begin n_mis++; $display("FAIL stall_pmis_de got %h want 0", dut.de_q); end
        n_cmp++; if (dut.fd_q !== ENT_P) begin n_mis++; $display("FAIL stall_pmis_fd got %h want %h", dut.fd_q, ENT_P); end
        n_cmp++; if (dut.em_q !== ENT_P) begin n_mis++; $display("FAIL stall_pmis_em got %h want %h", dut.em_q, ENT_P); end
        n_cmp++; if (bi.mis_cnt !== 32'd0) begin n_mis++; $display("FAIL stall_pmis_mis_cnt got %0d want 0", bi.mis_cnt); end
        bi.stall = 0; bi.pmis = 0; bi.branchM = 0; bi.pcF = PC_P;
    endtask

    task automatic test_reset_mid;
        bi.pcF = PC_P;
        tick; tick;
        bi.branchM = 1; bi.pcsrcM = 1;
        rst = 1;
        tick;
        rst = 0; bi.branchM = 0; bi.pcsrcM = 0;
        #1;
        n_cmp++; if (bi.pcsrcPF !== 1'b0) begin n_mis++; $display("FAIL rstmid_pred got %b want 0", bi.pcsrcPF); end
        n_cmp++; if (bi.br_cnt !== 32'd0) begin n_mis++; $display("FAIL rstmid_br_cnt got %0d want 0", bi.br_cnt); end
        n_cmp++; if (bi.mis_cnt !== 32'd0) begin n_mis++; $display("FAIL rstmid_mis_cnt got %0d want 0", bi.mis_cnt); end
        n_cmp++; if (dut.ghr_q !== 4'h0) begin n_mis++; $display("FAIL rstmid_ghr got %h want 0", dut.ghr_q); end
        n_cmp++; if (dut.em_q !== 19'd0) begin n_mis++; $display("FAIL rstmid_em got %h want 0", dut.em_q); end
        n_cmp++; if (dut.lpht_q[7'h4F] !== 2'b01) begin n_mis++; $display("FAIL rstmid_lpht got %b want 01", dut.lpht_q[7'h4F]); end
    endtask

    task automatic test_cnt_sat;
        ba.pcF = PC_P; ba.branchM = 1; ba.pmis = 1; ba.pcsrcM = 1;
        repeat (14) tick;
        n_cmp++; if (ba.br_cnt !== 4'hE) begin n_mis++; $display("FAIL sat14_br got %h want e", ba.br_cnt); end
        n_cmp++; if (ba.mis_cnt !== 4'hE) begin n_mis++; $display("FAIL sat14_mis got %h want e", ba.mis_cnt); end
        tick;
        n_cmp++; if (ba.br_cnt !== 4'hF) begin n_mis++; $display("FAIL sat15_br got %h want f", ba.br_cnt); end
        repeat (5) tick;
        n_cmp++; if (ba.br_cnt !== 4'hF) begin n_mis++; $display("FAIL sat20_br got %h want f", ba.br_cnt); end
        n_cmp++; if (ba.mis_cnt !== 4'hF) begin n_mis++; $display("FAIL sat20_mis got %h want f", ba.mis_cnt); end
        ba.branchM = 0; ba.pmis = 0; ba.pcsrcM = 0;
        rst_a = 1;
        tick;
        rst_a = 0;
        #1;
        n_cmp++; if (ba.mis_cnt !== 4'h0) begin n_mis++; $display("FAIL sat_rst_mis got %h want 0", ba.mis_cnt); end
    endtask

    // Six taken branches at PC_Q bias the gshare entries PC_P later lands on; local entries stay fresh.
    task automatic test_alternating;
        logic p;
        int   late_bad;
        logic exp_p [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        late_bad = 0;
        for (int i = 0; i < 6; i++) br_alt(PC_Q, 1'b1, p);
        n_cmp++; if (u_alt.gpht_q[1] !== 2'b11) begin n_mis++; $display("FAIL alt_bias_gpht got %b want 11", u_alt.gpht_q[1]); end
        for (int k = 0; k < 40; k++) begin
            br_alt(PC_P, (k % 2 == 0), p);
            if (k < 10) begin
                n_cmp++; if (p !== exp_p[k]) begin n_mis++; $display("FAIL alt_pred[%0d] got %b want %b", k, p, exp_p[k]); end
            end
            if (k >= 32 && p !== (k % 2 == 0)) late_bad++;
        end
        n_cmp++; if (late_bad !== 0) begin n_mis++; $display("FAIL alt_last8 got %0d wrong want 0", late_bad); end
        n_cmp++; if (u_alt.cho_q[1] !== 2'b11) begin n_mis++; $display("FAIL alt_chooser got %b want 11", u_alt.cho_q[1]); end
        n_cmp++; if (u_alt.lpht_q[7'h45] !== 2'b00) begin n_mis++; $display("FAIL alt_lpht45 got %b want 00", u_alt.lpht_q[7'h45]); end
        n_cmp++; if (u_alt.lpht_q[7'h4A] !== 2'b11) begin n_mis++; $display("FAIL alt_lpht4a got %b want 11", u_alt.lpht_q[7'h4A]); end
    endtask

    initial begin
        rst = 1; rst_a = 1;
        idle();
        test_reset();
        test_taken_train();
        test_stall();
        test_reset_mid();
        test_cnt_sat();
        test_alternating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
